// File: rtl/wb_queue.sv
// wb_queue: in-order write-back FIFO that owns the register-file write port, plus two bypass lookups.
// Defining WBQ_HOLD_EN adds the drain_hold input, which stalls retirement while pushes continue.
module wb_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    rf_wen,
    output logic [ADDR_WIDTH-1:0]   rf_waddr,
    output logic [DATA_WIDTH-1:0]   rf_wdata,
    input  logic [ADDR_WIDTH-1:0]   byp_addr1,
    input  logic [ADDR_WIDTH-1:0]   byp_addr2,
    output logic                    byp_hit1,
    output logic                    byp_hit2,
    output logic [DATA_WIDTH-1:0]   byp_data1,
    output logic [DATA_WIDTH-1:0]   byp_data2,
    output logic [$clog2(DEPTH):0]  count
`ifdef WBQ_HOLD_EN
    ,
    input  logic                    drain_hold
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_hold;
    logic [DATA_WIDTH:0]   w_byp1;
    logic [DATA_WIDTH:0]   w_byp2;

`ifdef WBQ_HOLD_EN
    assign w_hold = drain_hold;
`else
    assign w_hold = 1'b0;
`endif

    // Ready depends only on current occupancy: a same-cycle pop never frees a slot early.
    assign in_ready = (r_count != FULL);
    assign w_push   = in_valid && in_ready && (in_addr != '0);
    assign rf_wen   = (r_count != '0) && !w_hold;
    assign w_pop    = rf_wen;
    assign rf_waddr = r_addr[r_head];
    assign rf_wdata = r_data[r_head];
    assign count    = r_count;

    // Scan oldest to youngest so the last match (youngest) wins; returns {hit, data}.
    function automatic logic [DATA_WIDTH:0] lookup(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH:0] res;
        logic [PW-1:0]       idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (a != '0) && (r_addr[idx] == a))
                res = {1'b1, r_data[idx]};
        end
        return res;
    endfunction

    assign w_byp1    = lookup(byp_addr1);
    assign w_byp2    = lookup(byp_addr2);
    assign byp_hit1  = w_byp1[DATA_WIDTH];
    assign byp_data1 = w_byp1[DATA_WIDTH-1:0];
    assign byp_hit2  = w_byp2[DATA_WIDTH];
    assign byp_data2 = w_byp2[DATA_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_tail <= r_tail + 1'b1;
            if (w_pop)
                r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is only meaningful below r_count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= in_addr;
            r_data[r_tail] <= in_data;
        end
    end
endmodule

// File: tb/tb_wb_queue.sv
// Randomized scoreboard bench for wb_queue: a queue-based reference model predicts writes, occupancy and bypass.
module tb_wb_queue;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] byp_addr1 = '0;
    logic [AW-1:0] byp_addr2 = '0;
    logic          byp_hit1, byp_hit2;
    logic [DW-1:0] byp_data1, byp_data2;
    logic [CW-1:0] count;
    logic          hold = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    entry_t mdl[$];    // entries the model believes are queued, oldest first
    entry_t exp_q[$];  // expected register-file writes, popped by the monitor

    wb_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .byp_addr1(byp_addr1), .byp_addr2(byp_addr2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
        .count(count)
`ifdef WBQ_HOLD_EN
        , .drain_hold(hold)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO semantics straight from the rules, updated at each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl.delete();
            exp_q.delete();
        end else begin
            bit accept;
            accept = in_valid && (mdl.size() < DEPTH) && (in_addr != 0);
            if (mdl.size() > 0 && !hold)
                void'(mdl.pop_front());
            if (accept) begin
                mdl.push_back('{addr: in_addr, data: in_data});
                exp_q.push_back('{addr: in_addr, data: in_data});
            end
        end
    end

    function automatic logic [DW:0] ref_byp(input logic [AW-1:0] a);
        if (a == 0) return '0;
        for (int i = mdl.size() - 1; i >= 0; i--)
            if (mdl[i].addr == a) return {1'b1, mdl[i].data};
        return '0;
    endfunction

    // Monitor: checks DUT-visible state and retires expected writes as the DUT presents them.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [DW:0] b1, b2;
            b1 = ref_byp(byp_addr1);
            b2 = ref_byp(byp_addr2);
            chk("count", 64'(count), 64'(mdl.size()));
            chk("in_ready", 64'(in_ready), 64'(mdl.size() != DEPTH));
            chk("rf_wen", 64'(rf_wen), 64'(mdl.size() != 0 && !hold));
            chk("byp_hit1", 64'(byp_hit1), 64'(b1[DW]));
            chk("byp_data1", 64'(byp_data1), 64'(b1[DW-1:0]));
            chk("byp_hit2", 64'(byp_hit2), 64'(b2[DW]));
            chk("byp_data2", 64'(byp_data2), 64'(b2[DW-1:0]));
            if (rf_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(rf_waddr), 64'hFFFF_FFFF);
                end else begin
                    entry_t e;
                    e = exp_q.pop_front();
                    chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                    chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        byp_addr1 = 5'd5;
        step();
        step();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_wen", 64'(rf_wen), 64'd0);
        chk("reset_hit1", 64'(byp_hit1), 64'd0);
        chk("reset_data1", 64'(byp_data1), 64'd0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        step();

        // Single push into an empty queue, then drain.
        byp_addr1 = 5'd5;
        push(5'd5, 32'hDEAD_BEEF);
        chk("lat_wen", 64'(rf_wen), 64'd1);
        chk("lat_waddr", 64'(rf_waddr), 64'd5);
        chk("lat_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
        step();
        chk("lat_wen_after", 64'(rf_wen), 64'd0);
        chk("lat_count_after", 64'(count), 64'd0);

        // Register 0 is accepted but dropped.
        byp_addr1 = 5'd0;
        in_valid = 1'b1; in_addr = 5'd0; in_data = 32'h1234;
        #3;
        chk("r0_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("r0_count", 64'(count), 64'd0);
        chk("r0_wen", 64'(rf_wen), 64'd0);
        chk("r0_hit1", 64'(byp_hit1), 64'd0);

`ifdef WBQ_HOLD_EN
        // Fill under hold, reject a fifth push, then release and drain in order.
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(AW'(i), DW'(32'h100 + i));
        chk("hold_count", 64'(count), 64'd4);
        chk("hold_ready", 64'(in_ready), 64'd0);
        push(5'd9, 32'h999);
        chk("hold_count_full", 64'(count), 64'd4);
        hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("hold_drain_addr", 64'(rf_waddr), 64'(i));
            step();
        end
        chk("hold_drained", 64'(count), 64'd0);
`endif

        // Two writes to the same register: youngest visible through bypass, both retire.
        byp_addr2 = 5'd7;
        in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h11;
        step();
        in_data = 32'h22;
        step();
        in_valid = 1'b0;
        chk("same_hit2", 64'(byp_hit2), 64'd1);
        chk("same_data2", 64'(byp_data2), 64'h22);
        step();
        chk("same_hit2_drop", 64'(byp_hit2), 64'd0);

        // Sixteen back-to-back pushes: pointers wrap several times.
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_addr = AW'(1 + (i % 31));
            in_data = 32'hA000 + i;
            step();
            chk("stream_count", 64'(count), 64'd1);
        end
        in_valid = 1'b0;
        step();

        // Asynchronous reset with entries queued.
`ifdef WBQ_HOLD_EN
        hold = 1'b1;
`endif
        for (int i = 0; i < 3; i++) push(AW'(10 + i), DW'(32'hC0 + i));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_wen", 64'(rf_wen), 64'd0);
        hold = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_stale_wen", 64'(rf_wen), 64'd0);
        end

        // Randomized traffic with narrow address range to provoke bypass collisions.
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_addr   = AW'($urandom_range(0, 7));
            in_data   = $urandom;
            byp_addr1 = AW'($urandom_range(0, 7));
            byp_addr2 = AW'($urandom_range(0, 7));
`ifdef WBQ_HOLD_EN
            if ($urandom_range(0, 7) == 0) hold = ~hold;
`endif
            step();
        end
        in_valid = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) step();
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
